// File: rtl/run_ctrl.sv
// run_ctrl: run/stop/single-step controller for the nanoprocessor clock.
// Converts the selected divided level clock (slow or fast), or a debounced
// single-step button press, into one-cycle cpu_en pulses in the clk_50 domain.
// A HALT from the core parks the controller until reset.
//
// Ports:
//   clk_50      system clock, all logic on posedge
//   reset_n     synchronous reset, active low
//   slow_clk    divided level clock (slow), asynchronous, synchronised here
//   fast_clk    divided level clock (fast), asynchronous, synchronised here
//   speed_sel   0: tick on slow_clk, 1: tick on fast_clk
//   btn_run_n   active-low bouncy button, each accepted press toggles run/stop
//   btn_step_n  active-low bouncy button, each accepted press issues one step
//   halt        core HALT indication, synchronous to clk_50
//   cpu_en      one-cycle enable pulse to the core
//   running     high while in RUN
//   halted      high while in HALTED
//   instr_cnt   saturating count of cpu_en pulses since reset
module run_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 500_000,
  parameter int unsigned CNT_W           = 16
) (
  input  logic             clk_50,
  input  logic             reset_n,
  input  logic             slow_clk,
  input  logic             fast_clk,
  input  logic             speed_sel,
  input  logic             btn_run_n,
  input  logic             btn_step_n,
  input  logic             halt,
  output logic             cpu_en,
  output logic             running,
  output logic             halted,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam int unsigned DbW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DbW-1:0] DbMax = DbW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {StStop, StRun, StStep, StHalted} state_e;

  state_e state_q, state_d;
  logic   cpu_en_q, cpu_en_d;
  logic   running_q, halted_q;
  logic [CNT_W-1:0] cnt_q;

  // Clock synchronisers and rising-edge tick
  logic slow_s1_q, slow_s2_q, fast_s1_q, fast_s2_q;
  logic sel_prev_q, tick_q;
  logic sel_clk;

  // Button synchronisers and debouncers, index 0 = run, 1 = step
  logic [1:0]     btn_s1_q, btn_s2_q, filt_q, press_q;
  logic [DbW-1:0] db_cnt_q [2];

  assign sel_clk = speed_sel ? fast_s2_q : slow_s2_q;

  always_ff @(posedge clk_50) begin
    if (!reset_n) begin
      slow_s1_q  <= 1'b0;
      slow_s2_q  <= 1'b0;
      fast_s1_q  <= 1'b0;
      fast_s2_q  <= 1'b0;
      sel_prev_q <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      slow_s1_q  <= slow_clk;
      slow_s2_q  <= slow_s1_q;
      fast_s1_q  <= fast_clk;
      fast_s2_q  <= fast_s1_q;
      // Edge detect on the muxed level; a speed_sel flip can add or drop one tick.
      sel_prev_q <= sel_clk;
      tick_q     <= sel_clk & ~sel_prev_q;
    end
  end

  always_ff @(posedge clk_50) begin
    if (!reset_n) begin
      btn_s1_q <= 2'b11;
      btn_s2_q <= 2'b11;
      filt_q   <= 2'b11;
      press_q  <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        db_cnt_q[i] <= '0;
      end
    end else begin
      btn_s1_q <= {btn_step_n, btn_run_n};
      btn_s2_q <= btn_s1_q;
      for (int i = 0; i < 2; i++) begin
        press_q[i] <= 1'b0;
        // Counter only runs while the level differs from the filtered value, so
        // any bounce back to the filtered level restarts the qualification.
        if (btn_s2_q[i] == filt_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == DbMax) begin
          db_cnt_q[i] <= '0;
          filt_q[i]   <= btn_s2_q[i];
          press_q[i]  <= ~btn_s2_q[i];
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + DbW'(1);
        end
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cpu_en_d = 1'b0;
    unique case (state_q)
      StStop: begin
        if (halt)            state_d = StHalted;
        else if (press_q[0]) state_d = StRun;   // run wins over a same-cycle step
        else if (press_q[1]) state_d = StStep;
      end
      StRun: begin
        if (halt)            state_d = StHalted;
        else if (press_q[0]) state_d = StStop;
        else if (tick_q)     cpu_en_d = 1'b1;
      end
      StStep: begin
        cpu_en_d = 1'b1;
        state_d  = halt ? StHalted : StStop;
      end
      StHalted: begin
        state_d = StHalted;
      end
      default: begin
        state_d = StStop;
      end
    endcase
  end

  always_ff @(posedge clk_50) begin
    if (!reset_n) begin
      state_q   <= StStop;
      cpu_en_q  <= 1'b0;
      running_q <= 1'b0;
      halted_q  <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      cpu_en_q  <= cpu_en_d;
      running_q <= (state_d == StRun);
      halted_q  <= (state_d == StHalted);
      if (cpu_en_q && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign cpu_en    = cpu_en_q;
  assign running   = running_q;
  assign halted    = halted_q;
  assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_run_ctrl.sv
module tb_run_ctrl;

  logic        clk_50;
  logic        reset_n;
  logic        slow_clk, fast_clk, speed_sel;
  logic        btn_run_n, btn_step_n, halt;
  logic        cpu_en, running, halted;
  logic [15:0] instr_cnt;
  logic        cpu_en4, running4, halted4;
  logic [3:0]  instr_cnt4;

  int n_checks = 0;
  int n_pass   = 0;
  int en_pulses = 0;
  int en_double = 0;
  logic en_prev = 1'b0;

  run_ctrl #(.DEBOUNCE_CYCLES(4), .CNT_W(16)) dut (
    .clk_50(clk_50), .reset_n(reset_n), .slow_clk(slow_clk), .fast_clk(fast_clk),
    .speed_sel(speed_sel), .btn_run_n(btn_run_n), .btn_step_n(btn_step_n), .halt(halt),
    .cpu_en(cpu_en), .running(running), .halted(halted), .instr_cnt(instr_cnt)
  );

  run_ctrl #(.DEBOUNCE_CYCLES(4), .CNT_W(4)) dut4 (
    .clk_50(clk_50), .reset_n(reset_n), .slow_clk(slow_clk), .fast_clk(fast_clk),
    .speed_sel(speed_sel), .btn_run_n(btn_run_n), .btn_step_n(btn_step_n), .halt(halt),
    .cpu_en(cpu_en4), .running(running4), .halted(halted4), .instr_cnt(instr_cnt4)
  );

  initial clk_50 = 1'b0;
  always #5 clk_50 = ~clk_50;

  // Pulse monitor on the main instance
  always @(negedge clk_50) begin
    if (cpu_en) en_pulses++;
    if (cpu_en && en_prev) en_double++;
    en_prev = cpu_en;
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk_50);
      #1;
    end
  endtask

  task automatic press_run(input int hold);
    btn_run_n = 1'b0;
    cyc(hold);
    btn_run_n = 1'b1;
    cyc(10);
  endtask

  task automatic press_step(input int hold);
    btn_step_n = 1'b0;
    cyc(hold);
    btn_step_n = 1'b1;
    cyc(10);
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    cyc(2);
    n_checks++;
    if (cpu_en !== 1'b0) $display("FAIL reset_cpu_en got %b want 0", cpu_en);
    else n_pass++;
    n_checks++;
    if (running !== 1'b0) $display("FAIL reset_running got %b want 0", running);
    else n_pass++;
    n_checks++;
    if (halted !== 1'b0) $display("FAIL reset_halted got %b want 0", halted);
    else n_pass++;
    n_checks++;
    if (instr_cnt !== 16'd0) $display("FAIL reset_instr_cnt got %0d want 0", instr_cnt);
    else n_pass++;
    reset_n = 1'b1;
    cyc(2);
    repeat (3) begin
      slow_clk = 1'b1;
      cyc(4);
      slow_clk = 1'b0;
      cyc(4);
    end
    n_checks++;
    if (en_pulses !== 0) $display("FAIL stop_no_pulses got %0d want 0", en_pulses);
    else n_pass++;
    n_checks++;
    if (instr_cnt !== 16'd0 || running !== 1'b0)
      $display("FAIL stop_idle got cnt=%0d run=%b want cnt=0 run=0", instr_cnt, running);
    else n_pass++;
  endtask

  // One slow_clk period; cpu_en must be high exactly once, 4 cycles after the rise is driven
  task automatic slow_pulse(input int idx);
    int hits = 0;
    int pos  = 0;
    slow_clk = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk_50);
      #1;
      if (cpu_en === 1'b1) begin
        hits++;
        pos = c;
      end
      if (c == 4) slow_clk = 1'b0;
    end
    n_checks++;
    if (hits !== 1 || pos !== 4)
      $display("FAIL run_pulse%0d got hits=%0d pos=%0d want hits=1 pos=4", idx, hits, pos);
    else n_pass++;
  endtask

  task automatic test_run;
    press_run(6);
    n_checks++;
    if (running !== 1'b1 || halted !== 1'b0)
      $display("FAIL run_enter got run=%b halt=%b want run=1 halt=0", running, halted);
    else n_pass++;
    speed_sel = 1'b0;
    for (int i = 0; i < 5; i++) slow_pulse(i);
    n_checks++;
    if (instr_cnt !== 16'd5) $display("FAIL run_count got %0d want 5", instr_cnt);
    else n_pass++;
    n_checks++;
    if (en_double !== 0) $display("FAIL run_no_double got %0d want 0", en_double);
    else n_pass++;
  endtask

  task automatic test_bounce;
    btn_run_n = 1'b0;
    cyc(3);
    btn_run_n = 1'b1;
    cyc(12);
    n_checks++;
    if (running !== 1'b1) $display("FAIL bounce_running got %b want 1", running);
    else n_pass++;
  endtask

  task automatic test_step;
    int base;
    press_run(6);
    n_checks++;
    if (running !== 1'b0) $display("FAIL step_stop_enter got %b want 0", running);
    else n_pass++;
    base = en_pulses;
    press_step(6);
    n_checks++;
    if (en_pulses !== base + 1) $display("FAIL step_one_pulse got %0d want %0d", en_pulses, base + 1);
    else n_pass++;
    n_checks++;
    if (instr_cnt !== 16'd6) $display("FAIL step_count got %0d want 6", instr_cnt);
    else n_pass++;
    n_checks++;
    if (running !== 1'b0 || halted !== 1'b0)
      $display("FAIL step_back_stop got run=%b halt=%b want 0 0", running, halted);
    else n_pass++;
    press_run(6);
    base = en_pulses;
    press_step(6);
    n_checks++;
    if (en_pulses !== base || running !== 1'b1)
      $display("FAIL step_in_run got pulses=%0d run=%b want %0d 1", en_pulses, running, base);
    else n_pass++;
  endtask

  task automatic test_halt;
    int base;
    base = en_pulses;
    slow_clk = 1'b1;
    cyc(4);
    n_checks++;
    if (cpu_en !== 1'b1) $display("FAIL halt_pulse_live got %b want 1", cpu_en);
    else n_pass++;
    halt = 1'b1;
    cyc(1);
    halt = 1'b0;
    n_checks++;
    if (halted !== 1'b1 || running !== 1'b0 || cpu_en !== 1'b0)
      $display("FAIL halt_enter got halt=%b run=%b en=%b want 1 0 0", halted, running, cpu_en);
    else n_pass++;
    slow_clk = 1'b0;
    cyc(4);
    repeat (3) begin
      slow_clk = 1'b1;
      cyc(4);
      slow_clk = 1'b0;
      cyc(4);
    end
    press_run(6);
    press_step(6);
    n_checks++;
    if (en_pulses !== base + 1) $display("FAIL halt_no_pulses got %0d want %0d", en_pulses, base + 1);
    else n_pass++;
    n_checks++;
    if (instr_cnt !== 16'd7 || halted !== 1'b1 || running !== 1'b0)
      $display("FAIL halt_hold got cnt=%0d halt=%b run=%b want 7 1 0", instr_cnt, halted, running);
    else n_pass++;
    reset_n = 1'b0;
    cyc(1);
    reset_n = 1'b1;
    n_checks++;
    if (halted !== 1'b0 || running !== 1'b0 || cpu_en !== 1'b0 || instr_cnt !== 16'd0)
      $display("FAIL halt_reset got halt=%b run=%b en=%b cnt=%0d want 0 0 0 0",
               halted, running, cpu_en, instr_cnt);
    else n_pass++;
  endtask

  task automatic test_saturate;
    reset_n = 1'b0;
    cyc(2);
    reset_n = 1'b1;
    cyc(2);
    speed_sel = 1'b1;
    press_run(6);
    for (int i = 0; i < 20; i++) begin
      fast_clk = 1'b1;
      cyc(2);
      fast_clk = 1'b0;
      cyc(2);
    end
    cyc(6);
    n_checks++;
    if (instr_cnt4 !== 4'd15) $display("FAIL sat_cnt4 got %0d want 15", instr_cnt4);
    else n_pass++;
    n_checks++;
    if (instr_cnt !== 16'd20) $display("FAIL sat_cnt16 got %0d want 20", instr_cnt);
    else n_pass++;
    n_checks++;
    if (running4 !== 1'b1 || halted4 !== 1'b0)
      $display("FAIL sat_state got run=%b halt=%b want 1 0", running4, halted4);
    else n_pass++;
  endtask

  initial begin
    reset_n    = 1'b0;
    slow_clk   = 1'b0;
    fast_clk   = 1'b0;
    speed_sel  = 1'b0;
    btn_run_n  = 1'b1;
    btn_step_n = 1'b1;
    halt       = 1'b0;
    cyc(1);
    test_reset;
    test_run;
    test_bounce;
    test_step;
    test_halt;
    test_saturate;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
